jtopl_kon_sched: RTL and testbench

Key-on scheduler for the jtopl envelope generator. Accepts host key-on/key-off commands through a valid/ready queue, drains them one per operator slot into a shadow key-on register, and commits the shadow atomically at each frame boundary (`zero`). It then drives `keyon_I` to `jtopl_eg` in step with `jtopl_slot_cnt`. It sits between the register interface and `jtopl_eg`, replacing direct per-slot key-on wiring.

---
 rtl/jtopl_kon_pkg.sv | 16 +
 rtl/jtopl_kon_fifo.sv | 46 ++++
 rtl/jtopl_kon_sched.sv | 127 ++++++++++++
 tb/tb_jtopl_kon_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_kon_pkg.sv
// Shared types and constants for the jtopl key-on scheduler.
package jtopl_kon_pkg;

    localparam int SLOTS  = 18;
    localparam int SLOT_W = 5;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic              kon;
    } kon_cmd_t;

    function automatic logic slot_valid(input logic [SLOT_W-1:0] slot);
        return slot < SLOT_W'(SLOTS);
    endfunction

endpackage

// File: rtl/jtopl_kon_fifo.sv
// Synchronous FIFO of key-on commands; full/empty come straight from the registered pointers.
module jtopl_kon_fifo
    import jtopl_kon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  kon_cmd_t din,
    input  logic     pop,
    output kon_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    kon_cmd_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // The extra pointer bit separates the full and empty cases when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtopl_kon_sched.sv
// Key-on scheduler: queues host commands, drains them into a shadow mask and commits at frame start.
// Optional CSM key-on (one full frame of all-ones) is enabled with JTOPL_KON_CSM_EN.
module jtopl_kon_sched
    import jtopl_kon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cenop,
    input  logic              zero,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SLOT_W-1:0] cmd_slot,
    input  logic              cmd_kon,
    input  logic              csm_trig,
    output logic              keyon_I,
    output logic [SLOTS-1:0]  kon_active,
    output logic              busy,
    output logic              err
);

    kon_cmd_t          head;
    kon_cmd_t          cmd_in;
    logic              full;
    logic              empty;
    logic              pop;
    logic              commit;
    logic [SLOTS-1:0]  shadow;
    logic [SLOTS-1:0]  shadow_next;
    logic [SLOTS-1:0]  active_next;
    logic [SLOT_W-1:0] cur;
    logic [SLOT_W-1:0] cur_next;
    logic              err_next;

    // Handshake: a command transfers on any clk edge with cmd_valid && cmd_ready;
    // cmd_ready is simply !full and does not look ahead at a same-cycle pop.
    assign cmd_ready = !full;
    assign cmd_in    = '{slot: cmd_slot, kon: cmd_kon};
    assign pop       = cenop && !empty;
    assign commit    = cenop && zero;

    jtopl_kon_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef JTOPL_KON_CSM_EN
    logic csm_pend;
    logic csm_hold;
    logic csm_pend_next;
    logic csm_hold_next;
`endif

    always_comb begin
        shadow_next = shadow;
        err_next    = err;
        active_next = kon_active;
        cur_next    = cur;
`ifdef JTOPL_KON_CSM_EN
        csm_pend_next = csm_pend || csm_trig;
        csm_hold_next = csm_hold;
`endif
        if (pop) begin
            if (slot_valid(head.slot)) shadow_next[head.slot] = head.kon;
            else                       err_next = 1'b1;
        end
        if (commit) begin
`ifdef JTOPL_KON_CSM_EN
            if (csm_pend) begin
                active_next   = '1;
                csm_pend_next = csm_trig;
                csm_hold_next = 1'b1;
            end else begin
                active_next   = shadow_next;
                csm_hold_next = 1'b0;
            end
`else
            active_next = shadow_next;
`endif
        end
        if (cenop) begin
            if (zero || cur == SLOT_W'(SLOTS-1)) cur_next = '0;
            else                                 cur_next = cur + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            kon_active <= '0;
            cur        <= '0;
            keyon_I    <= 1'b0;
            err        <= 1'b0;
        end else begin
            shadow     <= shadow_next;
            kon_active <= active_next;
            cur        <= cur_next;
            err        <= err_next;
            // Index with the post-commit mask and post-advance slot so stage I sees the new state.
            if (cenop) keyon_I <= active_next[cur_next];
        end
    end

`ifdef JTOPL_KON_CSM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csm_pend <= 1'b0;
            csm_hold <= 1'b0;
        end else begin
            csm_pend <= csm_pend_next;
            csm_hold <= csm_hold_next;
        end
    end

    assign busy = !empty || (shadow != kon_active) || csm_pend || csm_hold;
`else
    assign busy = !empty || (shadow != kon_active);
`endif

endmodule

// File: tb/tb_jtopl_kon_sched.sv
// Directed bench for jtopl_kon_sched: vector table plus hand-written multi-cycle sequences.
module tb_jtopl_kon_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cenop;
    logic        zero;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_slot;
    logic        cmd_kon;
    logic        csm_trig;
    logic        keyon_I;
    logic [17:0] kon_active;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic exp_q[$];

    typedef struct {
        logic        cen;
        logic        zro;
        logic        vld;
        logic [4:0]  slot;
        logic        kon;
        logic        e_rdy;
        logic [17:0] e_ka;
        logic        e_keyon;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vec [30];

    jtopl_kon_sched #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cenop      (cenop),
        .zero       (zero),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_slot   (cmd_slot),
        .cmd_kon    (cmd_kon),
        .csm_trig   (csm_trig),
        .keyon_I    (keyon_I),
        .kon_active (kon_active),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [4:0] slot, input logic kon);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!cmd_ready) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_slot  = slot;
        cmd_kon   = kon;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic cen(input logic z);
        cenop = 1'b1;
        zero  = z;
        tick();
        cenop = 1'b0;
        zero  = 1'b0;
    endtask

    function automatic vec_t mk(input logic c, input logic z, input logic v, input logic [4:0] s,
                                input logic k, input logic rdy, input logic [17:0] ka,
                                input logic ko, input logic b, input logic e);
        vec_t r;
        r.cen = c; r.zro = z; r.vld = v; r.slot = s; r.kon = k;
        r.e_rdy = rdy; r.e_ka = ka; r.e_keyon = ko; r.e_busy = b; r.e_err = e;
        return r;
    endfunction

    function automatic check_outputs_reset(input string tag);
        return 1'b0;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_keyon"}, 32'(keyon_I), 32'd0);
        check({tag, "_ka"}, 32'(kon_active), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [17:0] mask;
        logic        e;

        rst = 1'b1; cenop = 1'b0; zero = 1'b0; cmd_valid = 1'b0;
        cmd_slot = '0; cmd_kon = 1'b0; csm_trig = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        //            cen z  vld slot kon | rdy ka        keyon busy err
        vec[0]  = mk(0, 0, 1, 5,  1,   1, 18'h00000, 0, 1, 0);
        vec[1]  = mk(1, 0, 0, 0,  0,   1, 18'h00000, 0, 1, 0);
        vec[2]  = mk(1, 1, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[3]  = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[4]  = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[5]  = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[6]  = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[7]  = mk(1, 0, 0, 0,  0,   1, 18'h00020, 1, 0, 0);
        vec[8]  = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[9]  = mk(0, 0, 1, 3,  1,   1, 18'h00020, 0, 1, 0);
        vec[10] = mk(0, 0, 1, 3,  0,   1, 18'h00020, 0, 1, 0);
        vec[11] = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 1, 0);
        vec[12] = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[13] = mk(1, 1, 0, 0,  0,   1, 18'h00020, 0, 0, 0);
        vec[14] = mk(0, 0, 1, 20, 1,   1, 18'h00020, 0, 1, 0);
        vec[15] = mk(1, 0, 0, 0,  0,   1, 18'h00020, 0, 0, 1);
        vec[16] = mk(1, 1, 0, 0,  0,   1, 18'h00020, 0, 0, 1);
        vec[17] = mk(1, 0, 1, 0,  1,   1, 18'h00020, 0, 1, 1);
        vec[18] = mk(1, 1, 0, 0,  0,   1, 18'h00021, 1, 0, 1);
        vec[19] = mk(1, 0, 0, 0,  0,   1, 18'h00021, 0, 0, 1);
        vec[20] = mk(0, 0, 1, 1,  1,   1, 18'h00021, 0, 1, 1);
        vec[21] = mk(0, 0, 1, 2,  1,   1, 18'h00021, 0, 1, 1);
        vec[22] = mk(0, 0, 1, 4,  1,   1, 18'h00021, 0, 1, 1);
        vec[23] = mk(0, 0, 1, 6,  1,   0, 18'h00021, 0, 1, 1);
        vec[24] = mk(1, 0, 1, 9,  1,   1, 18'h00021, 0, 1, 1);
        vec[25] = mk(1, 0, 0, 0,  0,   1, 18'h00021, 0, 1, 1);
        vec[26] = mk(1, 0, 0, 0,  0,   1, 18'h00021, 0, 1, 1);
        vec[27] = mk(1, 0, 0, 0,  0,   1, 18'h00021, 1, 1, 1);
        vec[28] = mk(1, 1, 0, 0,  0,   1, 18'h00077, 1, 0, 1);
        vec[29] = mk(0, 1, 0, 0,  0,   1, 18'h00077, 1, 0, 1);

        for (int i = 0; i < 30; i++) begin
            cenop     = vec[i].cen;
            zero      = vec[i].zro;
            cmd_valid = vec[i].vld;
            cmd_slot  = vec[i].slot;
            cmd_kon   = vec[i].kon;
            tick();
            check($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(vec[i].e_rdy));
            check($sformatf("v%0d_ka", i), 32'(kon_active), 32'(vec[i].e_ka));
            check($sformatf("v%0d_keyon", i), 32'(keyon_I), 32'(vec[i].e_keyon));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].e_busy));
            check($sformatf("v%0d_err", i), 32'(err), 32'(vec[i].e_err));
        end
        cenop = 1'b0; zero = 1'b0; cmd_valid = 1'b0;

        // Full-frame sweep without zero: cur runs 1..17 then wraps to 0 on its own.
        mask = 18'h00077;
        for (int c = 1; c <= 18; c++) exp_q.push_back(mask[c % 18]);
        for (int c = 1; c <= 18; c++) begin
            cen(1'b0);
            e = exp_q.pop_front();
            check($sformatf("sweep%0d_keyon", c), 32'(keyon_I), 32'(e));
        end

        // Fill every slot, commit, then reset with commands still queued.
        for (int s = 0; s < 18; s++) begin
            push_cmd(5'(s), 1'b1);
            cen(1'b0);
        end
        cen(1'b1);
        check("fill_ka", 32'(kon_active), 32'h3FFFF);
        check("fill_keyon", 32'(keyon_I), 32'd1);
        check("fill_err_sticky", 32'(err), 32'd1);
        push_cmd(5'd1, 1'b0);
        push_cmd(5'd2, 1'b0);
        push_cmd(5'd3, 1'b0);
        check("queued_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        cen(1'b1);
        check("post_rst_ka", 32'(kon_active), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // CSM: shadow holds slot 0 only, then a trigger pulse.
        push_cmd(5'd0, 1'b1);
        cen(1'b0);
        cen(1'b1);
        check("csm_pre_ka", 32'(kon_active), 32'h00001);
        csm_trig = 1'b1;
        tick();
        csm_trig = 1'b0;
`ifdef JTOPL_KON_CSM_EN
        check("csm_pend_busy", 32'(busy), 32'd1);
        cen(1'b1);
        check("csm_on_ka", 32'(kon_active), 32'h3FFFF);
        cen(1'b1);
        check("csm_off_ka", 32'(kon_active), 32'h00001);
        check("csm_off_busy", 32'(busy), 32'd0);
`else
        check("csm_ignored_busy", 32'(busy), 32'd0);
        cen(1'b1);
        check("csm_ignored_ka", 32'(kon_active), 32'h00001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
